sync_fifo_lvl: RTL and testbench

- Single-clock successor to the team's dual-clock FIFO: same write/read/full/empty contract, parametrised width and depth, with more status.
- Adds an exact fill level, programmable almost-full and almost-empty flags, and sticky overflow/underflow error flags.
- Used as the local buffer between same-clock pipeline stages, for example the fetch-to-decode and LSU response queues.
- Storage is an internal register array; there is no external memory instance.

---
 rtl/sync_fifo_lvl.sv | 110 +++++++++++
 tb/tb_sync_fifo_lvl.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/sync_fifo_lvl.sv
// sync_fifo_lvl: single-clock FIFO with exact fill level, programmable
// almost-full/almost-empty flags and sticky overflow/underflow flags.
// Optional build macro SYNC_FIFO_FWFT_EN selects first-word-fall-through
// read data; left undefined, read data is registered on an accepted read.
module sync_fifo_lvl #(
  parameter int DSIZE = 8,
  parameter int ASIZE = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_wr,
  input  logic [DSIZE-1:0] i_wdata,
  output logic             o_wfull,
  input  logic             i_rd,
  output logic [DSIZE-1:0] o_rdata,
  output logic             o_rempty,
  output logic [ASIZE:0]   o_level,
  input  logic [ASIZE:0]   i_afull_thresh,
  input  logic [ASIZE:0]   i_aempty_thresh,
  output logic             o_afull,
  output logic             o_aempty,
  output logic             o_overflow,
  output logic             o_underflow,
  input  logic             i_clr_err
);

  localparam int DEPTH = 1 << ASIZE;
  localparam logic [ASIZE:0] LVL_FULL = {1'b1, {ASIZE{1'b0}}};
  localparam logic [ASIZE:0] LVL_ONE  = {{ASIZE{1'b0}}, 1'b1};

  logic [DSIZE-1:0] r_mem [DEPTH];
  logic [ASIZE:0]   r_wptr, r_rptr, r_level;
  logic             r_wfull, r_rempty, r_afull, r_aempty;
  logic             r_overflow, r_underflow;

  logic             w_wr_ok, w_rd_ok;
  logic [ASIZE:0]   w_level_next;

  // Accepts are qualified by the registered flags only, so a pop never
  // makes room for a same-cycle push and vice versa.
  assign w_wr_ok      = i_wr & ~r_wfull;
  assign w_rd_ok      = i_rd & ~r_rempty;
  assign w_level_next = r_level + {{ASIZE{1'b0}}, w_wr_ok} - {{ASIZE{1'b0}}, w_rd_ok};

  // Storage write; contents are intentionally not cleared by reset.
  always_ff @(posedge i_clk) begin
    if (w_wr_ok)
      r_mem[r_wptr[ASIZE-1:0]] <= i_wdata;
  end

  // Pointers, level and all level-derived flags.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wptr   <= '0;
      r_rptr   <= '0;
      r_level  <= '0;
      r_wfull  <= 1'b0;
      r_rempty <= 1'b1;
      r_afull  <= 1'b0;
      r_aempty <= 1'b1;
    end else begin
      if (w_wr_ok) r_wptr <= r_wptr + LVL_ONE;
      if (w_rd_ok) r_rptr <= r_rptr + LVL_ONE;
      r_level  <= w_level_next;
      r_wfull  <= (w_level_next == LVL_FULL);
      r_rempty <= (w_level_next == '0);
      r_afull  <= (w_level_next >= i_afull_thresh);
      r_aempty <= (w_level_next <= i_aempty_thresh);
    end
  end

  // Sticky error flags; a new error in the clear cycle keeps the flag set.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (i_wr & r_wfull)  r_overflow  <= 1'b1;
      else if (i_clr_err)  r_overflow  <= 1'b0;
      if (i_rd & r_rempty) r_underflow <= 1'b1;
      else if (i_clr_err)  r_underflow <= 1'b0;
    end
  end

`ifdef SYNC_FIFO_FWFT_EN
  // Head entry is presented combinationally from the read pointer.
  assign o_rdata = r_mem[r_rptr[ASIZE-1:0]];
`else
  logic [DSIZE-1:0] r_rdata;

  // Registered read: data appears the cycle after an accepted read and holds.
  always_ff @(posedge i_clk) begin
    if (i_rst)
      r_rdata <= '0;
    else if (w_rd_ok)
      r_rdata <= r_mem[r_rptr[ASIZE-1:0]];
  end

  assign o_rdata = r_rdata;
`endif

  assign o_wfull     = r_wfull;
  assign o_rempty    = r_rempty;
  assign o_level     = r_level;
  assign o_afull     = r_afull;
  assign o_aempty    = r_aempty;
  assign o_overflow  = r_overflow;
  assign o_underflow = r_underflow;

endmodule

// File: tb/tb_sync_fifo_lvl.sv
// Testbench for sync_fifo_lvl: directed vector table, hand-written corner
// sequences and randomized traffic against a queue-based reference model.
module tb_sync_fifo_lvl;
  localparam int DSIZE = 8;
  localparam int ASIZE = 4;
  localparam int DEPTH = 16;

  logic             clk = 1'b0;
  logic             i_rst, i_wr, i_rd, i_clr_err;
  logic [DSIZE-1:0] i_wdata;
  logic [ASIZE:0]   afth, aeth;
  logic             o_wfull, o_rempty, o_afull, o_aempty, o_overflow, o_underflow;
  logic [DSIZE-1:0] o_rdata;
  logic [ASIZE:0]   o_level;

  always #5 clk = ~clk;

  sync_fifo_lvl #(.DSIZE(DSIZE), .ASIZE(ASIZE)) dut (
    .i_clk(clk), .i_rst(i_rst), .i_wr(i_wr), .i_wdata(i_wdata), .o_wfull(o_wfull),
    .i_rd(i_rd), .o_rdata(o_rdata), .o_rempty(o_rempty), .o_level(o_level),
    .i_afull_thresh(afth), .i_aempty_thresh(aeth), .o_afull(o_afull),
    .o_aempty(o_aempty), .o_overflow(o_overflow), .o_underflow(o_underflow),
    .i_clr_err(i_clr_err)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: contents as a queue, flags derived from its size.
  logic [7:0] q[$];
  bit         m_ovf, m_unf, m_afull, m_aempty;
  logic [7:0] m_rdata;

  typedef struct {
    bit         wr, rd, clr;
    logic [7:0] wdata;
    int         lvl;
    bit         full, empty, afull, aempty, ovf, unf, rdchk;
    logic [7:0] rdata;
  } vec_t;
  vec_t tbl[35];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cmp_model(input string tag);
    chk({tag, " level"},  32'(o_level), 32'(q.size()));
    chk({tag, " full"},   32'(o_wfull), 32'(q.size() == DEPTH));
    chk({tag, " empty"},  32'(o_rempty), 32'(q.size() == 0));
    chk({tag, " afull"},  32'(o_afull), 32'(m_afull));
    chk({tag, " aempty"}, 32'(o_aempty), 32'(m_aempty));
    chk({tag, " ovf"},    32'(o_overflow), 32'(m_ovf));
    chk({tag, " unf"},    32'(o_underflow), 32'(m_unf));
`ifndef SYNC_FIFO_FWFT_EN
    chk({tag, " rdata"},  32'(o_rdata), 32'(m_rdata));
`endif
  endtask

  // One clock of traffic; called and returns at a falling edge.
  task automatic step(input bit wr, input bit rd, input logic [7:0] wd, input bit clr);
    int sz;
    bit wok, rok;
    i_wr = wr; i_rd = rd; i_wdata = wd; i_clr_err = clr;
`ifdef SYNC_FIFO_FWFT_EN
    if (q.size() > 0) begin
      #1;
      chk("fwft head", 32'(o_rdata), 32'(q[0]));
    end
`endif
    @(posedge clk);
    sz  = q.size();
    wok = wr && (sz < DEPTH);
    rok = rd && (sz > 0);
    if (wr && sz == DEPTH) m_ovf = 1'b1; else if (clr) m_ovf = 1'b0;
    if (rd && sz == 0)     m_unf = 1'b1; else if (clr) m_unf = 1'b0;
    if (rok) m_rdata = q.pop_front();
    if (wok) q.push_back(wd);
    m_afull  = (q.size() >= int'(afth));
    m_aempty = (q.size() <= int'(aeth));
    @(negedge clk);
    cmp_model("step");
  endtask

  task automatic do_reset();
    i_rst = 1'b1; i_wr = 1'b0; i_rd = 1'b0; i_clr_err = 1'b0; i_wdata = '0;
    @(posedge clk);
    q.delete();
    m_ovf = 0; m_unf = 0; m_afull = 0; m_aempty = 1; m_rdata = '0;
    @(negedge clk);
    i_rst = 1'b0;
    cmp_model("reset");
  endtask

  initial begin
    i_rst = 1'b1; i_wr = 0; i_rd = 0; i_clr_err = 0; i_wdata = '0;
    afth = 5'd14; aeth = 5'd2;

    // Directed table: fill 16, overflow write, drain 16, underflow, clear.
    for (int i = 0; i < 16; i++)
      tbl[i] = '{wr:1, rd:0, clr:0, wdata:8'(i + 1), lvl:i + 1, full:(i == 15), empty:0,
                 afull:(i + 1 >= 14), aempty:(i + 1 <= 2), ovf:0, unf:0, rdchk:0, rdata:'0};
    tbl[16] = '{wr:1, rd:0, clr:0, wdata:8'hFF, lvl:16, full:1, empty:0,
                afull:1, aempty:0, ovf:1, unf:0, rdchk:0, rdata:'0};
    for (int j = 0; j < 16; j++)
      tbl[17 + j] = '{wr:0, rd:1, clr:0, wdata:'0, lvl:15 - j, full:0, empty:(j == 15),
                      afull:(15 - j >= 14), aempty:(15 - j <= 2), ovf:1, unf:0,
                      rdchk:1, rdata:8'(j + 1)};
    tbl[33] = '{wr:0, rd:1, clr:0, wdata:'0, lvl:0, full:0, empty:1,
                afull:0, aempty:1, ovf:1, unf:1, rdchk:0, rdata:'0};
    tbl[34] = '{wr:0, rd:0, clr:1, wdata:'0, lvl:0, full:0, empty:1,
                afull:0, aempty:1, ovf:0, unf:0, rdchk:0, rdata:'0};

    @(negedge clk);
    do_reset();
    // Reset then idle
    step(0, 0, 8'h00, 0);
    chk("idle empty", 32'(o_rempty), 1);
    chk("idle level", 32'(o_level), 0);
    chk("idle aempty", 32'(o_aempty), 1);
    chk("idle afull", 32'(o_afull), 0);

    for (int k = 0; k < 35; k++) begin
`ifdef SYNC_FIFO_FWFT_EN
      if (tbl[k].rdchk) chk($sformatf("tbl%0d rdata", k), 32'(o_rdata), 32'(tbl[k].rdata));
`endif
      step(tbl[k].wr, tbl[k].rd, tbl[k].wdata, tbl[k].clr);
      chk($sformatf("tbl%0d level", k), 32'(o_level), 32'(tbl[k].lvl));
      chk($sformatf("tbl%0d full", k), 32'(o_wfull), 32'(tbl[k].full));
      chk($sformatf("tbl%0d empty", k), 32'(o_rempty), 32'(tbl[k].empty));
      chk($sformatf("tbl%0d afull", k), 32'(o_afull), 32'(tbl[k].afull));
      chk($sformatf("tbl%0d aempty", k), 32'(o_aempty), 32'(tbl[k].aempty));
      chk($sformatf("tbl%0d ovf", k), 32'(o_overflow), 32'(tbl[k].ovf));
      chk($sformatf("tbl%0d unf", k), 32'(o_underflow), 32'(tbl[k].unf));
`ifndef SYNC_FIFO_FWFT_EN
      if (tbl[k].rdchk) chk($sformatf("tbl%0d rdata", k), 32'(o_rdata), 32'(tbl[k].rdata));
`endif
    end

    // Sustained push+pop at level 8 across pointer wrap.
    do_reset();
    for (int i = 0; i < 8; i++) step(1, 0, 8'(8'h40 + i), 0);
    for (int k = 0; k < 40; k++) begin
`ifdef SYNC_FIFO_FWFT_EN
      chk("steady head", 32'(o_rdata), (k < 8) ? 32'(8'h40 + k) : 32'(8'h80 + k - 8));
`endif
      step(1, 1, 8'(8'h80 + k), 0);
      chk("steady level", 32'(o_level), 8);
`ifndef SYNC_FIFO_FWFT_EN
      chk("steady rdata", 32'(o_rdata), (k < 8) ? 32'(8'h40 + k) : 32'(8'h80 + k - 8));
`endif
    end
    chk("steady ovf", 32'(o_overflow), 0);
    chk("steady unf", 32'(o_underflow), 0);

    // Full with push+pop: pop accepted, push dropped.
    for (int i = 0; i < 8; i++) step(1, 0, 8'(8'hC0 + i), 0);
    chk("full reached", 32'(o_wfull), 1);
    step(1, 1, 8'hEE, 0);
    chk("full wr+rd level", 32'(o_level), 15);
    chk("full wr+rd ovf", 32'(o_overflow), 1);
    // Empty with push+pop: push accepted, pop dropped.
    for (int i = 0; i < 15; i++) step(0, 1, 8'h00, 0);
    chk("drained", 32'(o_rempty), 1);
    step(1, 1, 8'h5A, 0);
    chk("empty wr+rd level", 32'(o_level), 1);
    chk("empty wr+rd unf", 32'(o_underflow), 1);
    step(0, 1, 8'h00, 0);
    // Clear together with a fresh underflow: set wins.
    step(0, 1, 8'h00, 1);
    chk("clr set-wins unf", 32'(o_underflow), 1);
    chk("clr ovf", 32'(o_overflow), 0);
    step(0, 0, 8'h00, 1);
    chk("clr unf", 32'(o_underflow), 0);

    // Reset mid-operation at level 9 with an error pending.
    step(0, 1, 8'h00, 0);
    for (int i = 0; i < 9; i++) step(1, 0, 8'(i), 0);
    chk("pre-reset level", 32'(o_level), 9);
    do_reset();
    chk("rst level", 32'(o_level), 0);
    chk("rst empty", 32'(o_rempty), 1);
    chk("rst unf", 32'(o_underflow), 0);

    // Thresholds above DEPTH: afull never, aempty always.
    afth = 5'd20; aeth = 5'd17;
    for (int i = 0; i < 16; i++) step(1, 0, 8'(i), 0);
    chk("hi-thresh afull", 32'(o_afull), 0);
    chk("hi-thresh aempty", 32'(o_aempty), 1);

    // Randomized traffic against the model.
    do_reset();
    for (int n = 0; n < 800; n++) begin
      int wbias;
      wbias = ((n / 100) % 2 == 0) ? 70 : 30;
      if (n % 50 == 0) begin
        afth = 5'($urandom_range(0, 20));
        aeth = 5'($urandom_range(0, 20));
      end
      step($urandom_range(0, 99) < wbias, $urandom_range(0, 99) < (100 - wbias),
           8'($urandom), $urandom_range(0, 99) < 5);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
